// File: rtl/bcd_digit_packer.sv
// Collects BCD digits MSD-first into a right-justified packed-BCD word and hands it
// downstream on valid/ready. Optional backspace input when BCD_BACKSPACE_EN is defined.
module bcd_digit_packer #(
  parameter  int DIGITS = 2,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef BCD_BACKSPACE_EN
  input  logic                bksp,
`endif
  input  logic                dig_valid,
  output logic                dig_ready,
  input  logic [3:0]          dig_in,
  input  logic                enter,
  output logic                bcd_valid,
  input  logic                bcd_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [CW-1:0]       digit_cnt,
  output logic                err
);

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                bksp_s;
  logic                legal_s;
  logic                take_s;
  logic                drop_s;
  logic [CW-1:0]       cnt_inc_s;

`ifdef BCD_BACKSPACE_EN
  assign bksp_s = bksp;
`else
  assign bksp_s = 1'b0;
`endif

  // A backspace request steals the digit slot so the offered digit stays with the source.
  assign dig_ready = (state_q == ST_ENTRY) && !bksp_s;
  assign legal_s   = (dig_in <= 4'd9);
  assign take_s    = dig_valid && dig_ready && legal_s;
  assign drop_s    = dig_valid && dig_ready && !legal_s;
  assign cnt_inc_s = cnt_q + CW'(1);

  // Next-state and next-word computation.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (bksp_s && (cnt_q != {CW{1'b0}})) begin
          bcd_d = bcd_q >> 4;
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (take_s) begin
            bcd_d = (bcd_q << 4) | (4*DIGITS)'(dig_in);
            cnt_d = cnt_inc_s;
          end else begin
            bcd_d = bcd_q;
            cnt_d = cnt_q;
          end
          err_d = drop_s;
          // Close on a full word, or on enter when the word will hold at least one digit.
          if ((take_s && (cnt_inc_s == CW'(DIGITS))) ||
              (enter && (take_s || (cnt_q != {CW{1'b0}})))) begin
            state_d = ST_OUT;
            valid_d = 1'b1;
          end else begin
            state_d = ST_ENTRY;
            valid_d = 1'b0;
          end
        end
      end
      ST_OUT: begin
        if (bcd_ready) begin
          bcd_d   = {(4*DIGITS){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = ST_ENTRY;
          valid_d = 1'b0;
        end else begin
          state_d = ST_OUT;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        bcd_d   = {(4*DIGITS){1'b0}};
        cnt_d   = {CW{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      bcd_q   <= {(4*DIGITS){1'b0}};
      cnt_q   <= {CW{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign digit_cnt = cnt_q;
  assign bcd_valid = valid_q;
  assign err       = err_q;

endmodule
